// File: rtl/atm_counter_reader_if.sv
// Bus bundle between the 64-bit counter reader, its requester and the counter.
// master = reader side; slave = requester/counter side.
interface atm_counter_reader_if #(
  parameter int DATA_W = 32
);
  logic                start_i;
  logic                busy_o;
  logic                req_o;
  logic                atomic_o;
  logic                ack_i;
  logic [DATA_W-1:0]   count_i;
  logic [2*DATA_W-1:0] value_o;
  logic                valid_o;
  logic                err_o;

  modport master (
    input  start_i, ack_i, count_i,
    output busy_o, req_o, atomic_o, value_o, valid_o, err_o
  );

  modport slave (
    output start_i, ack_i, count_i,
    input  busy_o, req_o, atomic_o, value_o, valid_o, err_o
  );
endinterface

// File: rtl/atm_counter_reader.sv
// Reads a 64-bit counter as two 32-bit bus reads (LSB then MSB) with ack timeout.
// Latency: start sampled at edge 0, valid_o in cycle 5; start ignored while busy.
module atm_counter_reader #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  atm_counter_reader_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    REQ_LO,
    WAIT_LO,
    REQ_HI,
    WAIT_HI,
    DONE
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [TO_W-1:0]       tcnt_q, tcnt_d;
  logic [DATA_W-1:0]     lo_q, lo_d;
  logic [2*DATA_W-1:0]   value_q, value_d;
  logic                  req_q, req_d;
  logic                  atomic_q, atomic_d;
  logic                  busy_q, busy_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      tcnt_q   <= '0;
      lo_q     <= '0;
      value_q  <= '0;
      req_q    <= 1'b0;
      atomic_q <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tcnt_q   <= tcnt_d;
      lo_q     <= lo_d;
      value_q  <= value_d;
      req_q    <= req_d;
      atomic_q <= atomic_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  // Outputs are computed for the next state so that they register in step with it.
  always_comb begin
    state_d  = state_q;
    tcnt_d   = tcnt_q;
    lo_d     = lo_q;
    value_d  = value_q;
    req_d    = 1'b0;
    atomic_d = 1'b0;
    valid_d  = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          state_d  = REQ_LO;
          req_d    = 1'b1;
          atomic_d = 1'b1;
        end
      end
      REQ_LO: begin
        state_d = WAIT_LO;
        tcnt_d  = '0;
      end
      WAIT_LO: begin
        // An ack on the last allowed cycle wins over the timeout.
        if (bus.ack_i) begin
          lo_d    = bus.count_i;
          state_d = REQ_HI;
          req_d   = 1'b1;
        end else if (tcnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tcnt_d = tcnt_q + TO_W'(1);
        end
      end
      REQ_HI: begin
        state_d = WAIT_HI;
        tcnt_d  = '0;
      end
      WAIT_HI: begin
        if (bus.ack_i) begin
          value_d = {bus.count_i, lo_q};
          state_d = DONE;
          valid_d = 1'b1;
        end else if (tcnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tcnt_d = tcnt_q + TO_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.req_o    = req_q;
  assign bus.atomic_o = atomic_q;
  assign bus.busy_o   = busy_q;
  assign bus.value_o  = value_q;
  assign bus.valid_o  = valid_q;
  assign bus.err_o    = err_q;

endmodule

// File: tb/tb_atm_counter_reader.sv
// Directed bench for atm_counter_reader: reset, basic read, timeout, late ack,
// back-to-back reads and spurious acks, with hand-computed expectations.
module tb_atm_counter_reader;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  atm_counter_reader_if #(.DATA_W(32)) bus ();

  atm_counter_reader #(.DATA_W(32), .TIMEOUT(15), .TO_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge: outputs show the new cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start_i = 1'b0;
    bus.ack_i   = 1'b0;
    bus.count_i = '0;
    tick();
    tick();
    n_cmp++;
    if ({bus.req_o, bus.atomic_o, bus.busy_o, bus.valid_o, bus.err_o} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags got=%b exp=00000", {bus.req_o, bus.atomic_o, bus.busy_o, bus.valid_o, bus.err_o});
    end
    n_cmp++;
    if (bus.value_o !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_value got=%h exp=0", bus.value_o);
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (bus.busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle busy got=%b exp=0", bus.busy_o);
    end
  endtask

  task automatic test_basic();
    bus.start_i = 1'b1;
    tick();                                   // cycle 1
    bus.start_i = 1'b0;
    n_cmp++;
    if ({bus.req_o, bus.atomic_o, bus.busy_o} !== 3'b111) begin
      n_fail++;
      $display("FAIL basic_req_lo req/atomic/busy got=%b exp=111", {bus.req_o, bus.atomic_o, bus.busy_o});
    end
    tick();                                   // cycle 2
    n_cmp++;
    if ({bus.req_o, bus.busy_o} !== 2'b01) begin
      n_fail++;
      $display("FAIL basic_wait_lo req/busy got=%b exp=01", {bus.req_o, bus.busy_o});
    end
    bus.ack_i   = 1'b1;
    bus.count_i = 32'hFFFF_FFFE;
    tick();                                   // cycle 3
    bus.ack_i = 1'b0;
    n_cmp++;
    if ({bus.req_o, bus.atomic_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL basic_req_hi req/atomic got=%b exp=10", {bus.req_o, bus.atomic_o});
    end
    tick();                                   // cycle 4
    n_cmp++;
    if ({bus.req_o, bus.valid_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL basic_wait_hi req/valid got=%b exp=00", {bus.req_o, bus.valid_o});
    end
    bus.ack_i   = 1'b1;
    bus.count_i = 32'h0000_0001;
    tick();                                   // cycle 5
    bus.ack_i = 1'b0;
    n_cmp++;
    if (bus.valid_o !== 1'b1 || bus.value_o !== 64'h0000_0001_FFFF_FFFE) begin
      n_fail++;
      $display("FAIL basic_done valid=%b value=%h exp valid=1 value=0000_0001_fffffffe", bus.valid_o, bus.value_o);
    end
    tick();                                   // cycle 6
    n_cmp++;
    if ({bus.valid_o, bus.busy_o, bus.err_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL basic_idle valid/busy/err got=%b exp=000", {bus.valid_o, bus.busy_o, bus.err_o});
    end
  endtask

  task automatic test_reset_mid();
    bus.start_i = 1'b1;
    tick();                                   // cycle 1
    bus.start_i = 1'b0;
    tick();                                   // cycle 2
    bus.ack_i   = 1'b1;
    bus.count_i = 32'h1111_1111;
    tick();                                   // cycle 3
    bus.ack_i = 1'b0;
    tick();                                   // cycle 4, WAIT_HI
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.req_o, bus.atomic_o, bus.busy_o, bus.valid_o, bus.err_o} !== 5'b0 || bus.value_o !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_mid flags=%b value=%h exp flags=00000 value=0",
               {bus.req_o, bus.atomic_o, bus.busy_o, bus.valid_o, bus.err_o}, bus.value_o);
    end
    tick();
    tick();
    rst_n = 1'b1;
    bus.ack_i   = 1'b1;
    bus.count_i = 32'h2222_2222;
    for (int i = 0; i < 8; i++) begin
      tick();
      bus.ack_i = 1'b0;
      n_cmp++;
      if ({bus.valid_o, bus.err_o, bus.busy_o} !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_mid_after cyc=%0d valid/err/busy got=%b exp=000", i, {bus.valid_o, bus.err_o, bus.busy_o});
      end
    end
  endtask

  task automatic test_late_ack();
    bus.start_i = 1'b1;
    tick();                                   // cycle 1
    bus.start_i = 1'b0;
    tick();                                   // cycle 2, first WAIT_LO cycle
    for (int i = 0; i < 14; i++) tick();      // cycle 16, 15th WAIT_LO cycle
    n_cmp++;
    if (bus.err_o !== 1'b0 || bus.busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL late_lo_wait err/busy got=%b%b exp=01", bus.err_o, bus.busy_o);
    end
    bus.ack_i   = 1'b1;
    bus.count_i = 32'h1234_5678;
    tick();                                   // cycle 17
    bus.ack_i = 1'b0;
    n_cmp++;
    if ({bus.req_o, bus.atomic_o, bus.err_o} !== 3'b100) begin
      n_fail++;
      $display("FAIL late_lo_ack req/atomic/err got=%b exp=100", {bus.req_o, bus.atomic_o, bus.err_o});
    end
    tick();                                   // cycle 18, first WAIT_HI cycle
    for (int i = 0; i < 14; i++) tick();      // cycle 32, 15th WAIT_HI cycle
    bus.ack_i   = 1'b1;
    bus.count_i = 32'h9ABC_DEF0;
    tick();                                   // cycle 33
    bus.ack_i = 1'b0;
    n_cmp++;
    if (bus.valid_o !== 1'b1 || bus.err_o !== 1'b0 || bus.value_o !== 64'h9ABC_DEF0_1234_5678) begin
      n_fail++;
      $display("FAIL late_hi_ack valid=%b err=%b value=%h exp valid=1 err=0 value=9abcdef012345678",
               bus.valid_o, bus.err_o, bus.value_o);
    end
    tick();
  endtask

  task automatic test_timeout();
    bus.start_i = 1'b1;
    tick();                                   // cycle 1
    bus.start_i = 1'b0;
    tick();                                   // cycle 2, first WAIT_LO cycle
    for (int c = 3; c <= 16; c++) begin
      tick();
      n_cmp++;
      if (bus.err_o !== 1'b0 || bus.busy_o !== 1'b1) begin
        n_fail++;
        $display("FAIL timeout_early cyc=%0d err/busy got=%b%b exp=01", c, bus.err_o, bus.busy_o);
      end
    end
    tick();                                   // cycle 17
    n_cmp++;
    if (bus.err_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_err err/busy/valid got=%b%b%b exp=100", bus.err_o, bus.busy_o, bus.valid_o);
    end
    n_cmp++;
    if (bus.value_o !== 64'h9ABC_DEF0_1234_5678) begin
      n_fail++;
      $display("FAIL timeout_value got=%h exp=9abcdef012345678", bus.value_o);
    end
    tick();
    n_cmp++;
    if (bus.err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_pulse err got=%b exp=0", bus.err_o);
    end
  endtask

  task automatic test_back_to_back();
    logic prev_req, prev_atomic;
    logic exp_req, exp_atomic, exp_valid, exp_busy;
    prev_req    = 1'b0;
    prev_atomic = 1'b0;
    bus.start_i = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      tick();
      if (c == 19) bus.start_i = 1'b0;
      bus.ack_i   = prev_req;
      bus.count_i = prev_atomic ? 32'hCAFE_0001 : 32'h0000_00B2;
      exp_req    = (c % 6 == 1) || (c % 6 == 3);
      exp_atomic = (c % 6 == 1);
      exp_valid  = (c % 6 == 5);
      exp_busy   = (c % 6 != 0);
      n_cmp++;
      if ({bus.req_o, bus.atomic_o, bus.valid_o, bus.busy_o} !== {exp_req, exp_atomic, exp_valid, exp_busy}) begin
        n_fail++;
        $display("FAIL b2b cyc=%0d req/atomic/valid/busy got=%b exp=%b", c,
                 {bus.req_o, bus.atomic_o, bus.valid_o, bus.busy_o}, {exp_req, exp_atomic, exp_valid, exp_busy});
      end
      if (exp_valid) begin
        n_cmp++;
        if (bus.value_o !== 64'h0000_00B2_CAFE_0001) begin
          n_fail++;
          $display("FAIL b2b_value cyc=%0d got=%h exp=000000b2cafe0001", c, bus.value_o);
        end
      end
      prev_req    = bus.req_o;
      prev_atomic = bus.atomic_o;
    end
    bus.ack_i = 1'b0;
    tick();
    n_cmp++;
    if (bus.busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_stop busy got=%b exp=0", bus.busy_o);
    end
  endtask

  task automatic test_spurious();
    bus.ack_i   = 1'b1;
    bus.count_i = 32'hDEAD_BEEF;
    tick();
    bus.ack_i = 1'b0;
    n_cmp++;
    if (bus.busy_o !== 1'b0 || bus.valid_o !== 1'b0 || bus.value_o !== 64'h0000_00B2_CAFE_0001) begin
      n_fail++;
      $display("FAIL spur_idle busy=%b valid=%b value=%h exp 0 0 000000b2cafe0001", bus.busy_o, bus.valid_o, bus.value_o);
    end
    bus.start_i = 1'b1;
    tick();                                   // cycle 1
    bus.start_i = 1'b0;
    tick();                                   // cycle 2
    bus.ack_i   = 1'b1;
    bus.count_i = 32'hAAAA_5555;
    tick();                                   // cycle 3, REQ_HI
    bus.count_i = 32'hDEAD_BEEF;              // ack still high, sampled in REQ_HI
    tick();                                   // cycle 4, WAIT_HI
    bus.ack_i   = 1'b0;
    bus.start_i = 1'b1;                       // dropped: reader is busy
    n_cmp++;
    if (bus.valid_o !== 1'b0 || bus.busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL spur_reqhi valid/busy got=%b%b exp=01", bus.valid_o, bus.busy_o);
    end
    tick();                                   // cycle 5
    bus.start_i = 1'b0;
    bus.ack_i   = 1'b1;
    bus.count_i = 32'h0F0F_0F0F;
    tick();                                   // cycle 6, DONE
    bus.count_i = 32'hDEAD_BEEF;              // second ack after WAIT_HI left
    n_cmp++;
    if (bus.valid_o !== 1'b1 || bus.value_o !== 64'h0F0F_0F0F_AAAA_5555) begin
      n_fail++;
      $display("FAIL spur_done valid=%b value=%h exp valid=1 value=0f0f0f0faaaa5555", bus.valid_o, bus.value_o);
    end
    tick();                                   // cycle 7
    bus.ack_i = 1'b0;
    tick();                                   // cycle 8
    n_cmp++;
    if (bus.busy_o !== 1'b0 || bus.valid_o !== 1'b0 || bus.value_o !== 64'h0F0F_0F0F_AAAA_5555) begin
      n_fail++;
      $display("FAIL spur_after busy=%b valid=%b value=%h exp 0 0 0f0f0f0faaaa5555", bus.busy_o, bus.valid_o, bus.value_o);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_basic();
    test_reset_mid();
    test_late_ack();
    test_timeout();
    test_back_to_back();
    test_spurious();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
